data_mem_unit: RTL



---
 rtl/data_mem_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/data_mem_unit.sv
// Byte-addressable data memory with a valid/ready request port and a fixed-latency
// response pulse; byte/half/word loads and stores, little-endian, with fault detection.
module data_mem_unit #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);
    localparam int DEPTH = 2 ** (ADDR_W - 2);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        accept;

    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic [31:0] mem [DEPTH];

    logic [ADDR_W-3:0] idx;
    logic [31:0] rd_word, wr_word, load_data;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [4:0]  bsh, hsh;
    logic        err;

    assign accept = req_valid && req_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT: if (cnt == 4'd0) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt <= 4'd0;
        else if (state == IDLE && accept)
            cnt <= (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
        else if (state == WAIT && cnt != 4'd0)
            cnt <= cnt - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_we       <= 1'b0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_addr     <= 32'd0;
            lat_wdata    <= 32'd0;
        end else if (state == IDLE && accept) begin
            lat_we       <= req_we;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_addr     <= req_addr;
            lat_wdata    <= req_wdata;
        end
    end

    // Fault and data path all work from the latched request
    always_comb begin
        err = (lat_size == 2'b11) ||
              (lat_size == 2'b01 && lat_addr[0]) ||
              (lat_size == 2'b10 && lat_addr[1:0] != 2'b00) ||
              ((lat_addr >> ADDR_W) != 32'd0);
        idx     = lat_addr[ADDR_W-1:2];
        rd_word = mem[idx];
        bsh     = {lat_addr[1:0], 3'b000};
        hsh     = {lat_addr[1], 4'b0000};
        byte_v  = rd_word[bsh +: 8];
        half_v  = rd_word[hsh +: 16];

        case (lat_size)
            2'b00:   load_data = lat_unsigned ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
            2'b01:   load_data = lat_unsigned ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
            default: load_data = rd_word;
        endcase

        wr_word = rd_word;
        case (lat_size)
            2'b00:   wr_word[bsh +: 8]  = lat_wdata[7:0];
            2'b01:   wr_word[hsh +: 16] = lat_wdata[15:0];
            default: wr_word = lat_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
        end else if (state == RESP && lat_we && !err) begin
            mem[idx] <= wr_word;
        end
    end

    // Response fields change only on the response edge and hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= (state == RESP);
            if (state == RESP) begin
                resp_err   <= err;
                resp_rdata <= (err || lat_we) ? 32'd0 : load_data;
            end
        end
    end
endmodule
